// File: rtl/jk_seq_pkg.sv
// rtl/jk_seq_pkg.sv - shared types, op encodings and JK helpers for the JK command sequencer
package jk_seq_pkg;

  // Width of the repeat-length field carried in a queued command
  localparam int CMD_LEN_W = 4;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_RST  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TOG  = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  // Op sits in the upper bits so the FIFO word is simply {op, len}
  typedef struct packed {
    logic [1:0]           op;
    logic [CMD_LEN_W-1:0] len;
  } cmd_t;

  // Drive pair {J, K} for a command op
  function automatic logic [1:0] op_to_jk(input logic [1:0] op);
    logic [1:0] jk;
    case (op)
      OP_RST:  jk = 2'b01;
      OP_SET:  jk = 2'b10;
      OP_TOG:  jk = 2'b11;
      default: jk = 2'b00;
    endcase
    return jk;
  endfunction

  // Next Q of an ideal JK flip-flop
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic qn;
    case ({j, k})
      2'b10:   qn = 1'b1;
      2'b01:   qn = 1'b0;
      2'b11:   qn = ~q;
      default: qn = q;
    endcase
    return qn;
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// rtl/jk_cmd_fifo.sv - synchronous command FIFO with full/empty/count status
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  // Requests are qualified here so a push on full or pop on empty is ignored
  assign w_wr    = i_push & ~o_full;
  assign w_rd    = i_pop & ~o_empty;
  assign o_full  = (r_count == L_FULL);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  // Storage array; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// rtl/jk_cmd_sequencer.sv - queued command stream to registered J/K drive with a Q reference model
module jk_cmd_sequencer
  import jk_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LEN_W = CMD_LEN_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [LEN_W-1:0]        cmd_len,
  output logic                    J,
  output logic                    K,
  input  logic                    q_fb,
  output logic                    q_pred,
  output logic                    busy,
  output logic                    mismatch,
  input  logic                    err_clr,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  logic [LEN_W+1:0]  w_rdata;
  cmd_t              w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  w_cnt_nxt;
  logic              r_j;
  logic              r_k;
  logic              w_j_nxt;
  logic              w_k_nxt;
  logic              r_q_pred;
  logic              r_mismatch;
  logic              r_chk_en;

  jk_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (LEN_W + 2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (cmd_valid),
    .i_wdata ({cmd_op, cmd_len}),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  // The packed command struct fixes the length width to CMD_LEN_W
  assign w_head    = cmd_t'(w_rdata);
  assign cmd_ready = ~w_full;
  assign J         = r_j;
  assign K         = r_k;
  assign q_pred    = r_q_pred;
  assign busy      = (r_state == DRIVE);
  assign mismatch  = r_mismatch;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: leave DRIVE only when the last cycle ends with nothing queued
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = w_empty ? IDLE : DRIVE;
      DRIVE:   w_state_nxt = ((r_cnt == '0) && w_empty) ? IDLE : DRIVE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: pop request and next drive/counter values, loading back-to-back with no bubble
  always_comb begin
    w_pop     = 1'b0;
    w_cnt_nxt = r_cnt;
    w_j_nxt   = r_j;
    w_k_nxt   = r_k;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop              = 1'b1;
          w_cnt_nxt          = w_head.len;
          {w_j_nxt, w_k_nxt} = op_to_jk(w_head.op);
        end else begin
          w_j_nxt = 1'b0;
          w_k_nxt = 1'b0;
        end
      end
      DRIVE: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (!w_empty) begin
          w_pop              = 1'b1;
          w_cnt_nxt          = w_head.len;
          {w_j_nxt, w_k_nxt} = op_to_jk(w_head.op);
        end else begin
          w_j_nxt = 1'b0;
          w_k_nxt = 1'b0;
        end
      end
      default: begin
        w_j_nxt = 1'b0;
        w_k_nxt = 1'b0;
      end
    endcase
  end

  // Drive registers and repeat counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_j   <= 1'b0;
      r_k   <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_j   <= w_j_nxt;
      r_k   <= w_k_nxt;
    end
  end

  // Reference model: advances from the same J/K the downstream flop samples this edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q_pred <= 1'b0;
    end else begin
      r_q_pred <= jk_next(r_q_pred, r_j, r_k);
    end
  end

  // Sticky divergence flag; checking starts one edge after reset release and a new difference beats err_clr
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_chk_en   <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      r_chk_en <= 1'b1;
      if (r_chk_en && (q_fb != r_q_pred)) begin
        r_mismatch <= 1'b1;
      end else if (err_clr) begin
        r_mismatch <= 1'b0;
      end
    end
  end

endmodule

// File: doc/jk_cmd_sequencer.md
Name: jk_cmd_sequencer

Overview:
- Upstream driver for the SR-based JK flip-flop stage; converts a queued command stream into per-cycle J/K drive.
- Commands (hold/reset/set/toggle, each with a repeat length) enter through a valid/ready handshake and are buffered in a small FIFO.
- The block runs a reference JK model of the downstream flip-flop and flags any divergence on the fed-back Q.

Parameters:
- DEPTH, 4: command FIFO entries; power of two, at least 2.
- LEN_W, 4: width of the per-command repeat-length field.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- cmd_valid, input, 1: command offered this cycle.
- cmd_ready, output, 1: FIFO can accept; equals not-full, registered-state only.
- cmd_op, input, 2: 00 hold, 01 reset, 10 set, 11 toggle.
- cmd_len, input, LEN_W: apply the op for cmd_len+1 cycles.
- J, output, 1: registered drive to the downstream J input.
- K, output, 1: registered drive to the downstream K input.
- q_fb, input, 1: Q returned from the downstream flip-flop.
- q_pred, output, 1: model of the expected downstream Q.
- busy, output, 1: high while in DRIVE.
- mismatch, output, 1: sticky flag, set when q_fb differs from q_pred.
- err_clr, input, 1: clears mismatch.
- fifo_count, output, log2(DEPTH)+1: current FIFO occupancy.

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO emptied, fifo_count=0, cmd_ready=1.
  - State=IDLE, J=K=0, q_pred=0, mismatch=0, busy=0.
  - Reset asserted mid-command aborts that command; nothing resumes after release.
- Push: occurs on an edge where cmd_valid and cmd_ready are both high.
  - cmd_ready does not depend on a same-cycle pop; a full FIFO with a pop still refuses the push.
- Op-to-drive mapping, held for the whole command:
  - hold: J=0, K=0.
  - reset: J=0, K=1.
  - set: J=1, K=0.
  - toggle: J=1, K=1.
- IDLE: J=K=0, busy=0.
  - If the FIFO is non-empty: pop, load cnt=cmd_len, drive J/K per the mapping, go to DRIVE. All take effect on the same edge.
  - Latency: a command pushed at edge N into an empty FIFO with the block in IDLE gives J/K valid after edge N+1.
- DRIVE: busy=1, J/K held.
  - If cnt>0: decrement cnt.
  - If cnt=0 and the FIFO is non-empty: pop the next command and load it with no bubble cycle.
  - If cnt=0 and the FIFO is empty: J=K=0, go to IDLE.
  - cmd_len=0 gives exactly one drive cycle; cmd_len=2^LEN_W-1 gives 2^LEN_W cycles. No overflow.
- q_pred model, updated every edge from the current J/K (the same values the downstream flop samples on that edge):
  - 10 sets 1; 01 sets 0; 11 inverts; 00 holds.
- Mismatch check:
  - Compare q_fb with q_pred every cycle, starting from the second cycle after reset release.
  - On a difference, mismatch is set on the next edge.
  - If err_clr and a new difference occur in the same cycle, the set wins.
- Simultaneous push and pop when non-full: fifo_count is unchanged and the pointers wrap modulo DEPTH.
- Pushing into an empty FIFO while in DRIVE with cnt=0: the new entry is not visible until the next edge (no bypass), so one IDLE cycle occurs.

Decomposition:
- Package jk_seq_pkg holds:
  - op encodings OP_HOLD, OP_RST, OP_SET, OP_TOG;
  - state enum IDLE/DRIVE;
  - the packed command struct {op, len}.
- Sub-module jk_cmd_fifo: synchronous FIFO, DEPTH x (2+LEN_W), with full/empty/count outputs and the same asynchronous active-low reset.
- The top level holds the FSM, the repeat counter, the q_pred model and the mismatch logic.

Test Plan:
- Reset, then push set len=0 at edge 3: J=1, K=0 for exactly one cycle after edge 4; q_pred=1 from edge 5; then J=K=0 and busy=0.
- Push toggle len=3 then reset len=1 back-to-back, with a real JK model on q_fb:
  - J=K=1 for 4 cycles, then J=0, K=1 for 2 cycles, with no gap;
  - q_pred sequence 1,0,1,0, then 0,0; mismatch=0.
- Hold cmd_valid high with DRIVE stalled by len=15 commands:
  - cmd_ready drops after 4 accepts and fifo_count=4;
  - ready returns one edge after the first pop.
- Force q_fb=0 during a set command: mismatch rises on the next edge and stays high; pulse err_clr after fixing q_fb, and mismatch returns to 0.
- Assert rst mid-toggle len=10 at cycle 5 of the command: J, K, q_pred and fifo_count go to 0 immediately; after release, J=K=0 and the block is IDLE.
- Wrap-around: 12 mixed commands through the DEPTH=4 FIFO; the drive sequence matches push order exactly.
